// File: rtl/delay_line_prog.sv
// Runtime-programmable stream delay line.
// Delays a {valid, data} stream by 1..MAX_DLY enabled clocks using a circular buffer.
// A per-slot valid flag lets a reprogram flush the line without clearing the data RAM.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        asynchronous active-low reset
//   cfg_dly    requested delay, sampled on cfg_load
//   cfg_load   strobe: apply cfg_dly (clamped to 1..MAX_DLY) and flush the line
//   sti_en     clock enable; 0 freezes the line
//   sti_valid  input valid
//   sti_data   input data
//   sto_valid  output valid (registered)
//   sto_data   output data (registered)
//   cur_dly    delay currently in effect
//   busy       line is refilling after reset or cfg_load
module delay_line_prog #(
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_DLY = 16,
    parameter int unsigned DEF_DLY = 3,
    localparam int unsigned AW     = $clog2(MAX_DLY) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cfg_dly,
    input  logic          cfg_load,
    input  logic          sti_en,
    input  logic          sti_valid,
    input  logic [DW-1:0] sti_data,
    output logic          sto_valid,
    output logic [DW-1:0] sto_data,
    output logic [AW-1:0] cur_dly,
    output logic          busy
);

    localparam int unsigned PW = $clog2(MAX_DLY);

    logic [DW-1:0]      mem_q [MAX_DLY];
    logic [MAX_DLY-1:0] vld_q, vld_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_idx;
    logic [AW:0]        rd_sum;
    logic [AW-1:0]      cur_dly_q, cur_dly_d;
    logic [AW-1:0]      fill_q, fill_d, fill_base;
    logic [AW-1:0]      dly_clamp, dly_eff;
    logic               rd_valid;
    logic [DW-1:0]      rd_data;
    logic               sto_valid_q, sto_valid_d;
    logic [DW-1:0]      sto_data_q, sto_data_d;

    // Requested delay forced into 1..MAX_DLY.
    always_comb begin
        dly_clamp = cfg_dly;
        if (cfg_dly == '0) begin
            dly_clamp = AW'(1);
        end else if (cfg_dly > AW'(MAX_DLY)) begin
            dly_clamp = AW'(MAX_DLY);
        end
    end

    // A load takes effect on its own edge, so a same-cycle sample already uses the new delay.
    assign dly_eff = cfg_load ? dly_clamp : cur_dly_q;

    // Read slot (wr_ptr - D + 1) mod MAX_DLY, kept non-negative by adding MAX_DLY first.
    always_comb begin
        rd_sum = (AW+1)'(wr_ptr_q) + (AW+1)'(MAX_DLY + 1) - (AW+1)'(dly_eff);
        if (rd_sum >= (AW+1)'(MAX_DLY)) begin
            rd_sum = rd_sum - (AW+1)'(MAX_DLY);
        end
        rd_idx = PW'(rd_sum);
    end

    // D=1 reads the slot being written this cycle, so bypass straight from the input.
    // On a load edge every older slot is stale, so only the bypass can be valid.
    always_comb begin
        if (dly_eff == AW'(1)) begin
            rd_valid = sti_valid;
            rd_data  = sti_data;
        end else begin
            rd_valid = cfg_load ? 1'b0 : vld_q[rd_idx];
            rd_data  = mem_q[rd_idx];
        end
    end

    always_comb begin
        cur_dly_d   = cur_dly_q;
        fill_base   = fill_q;
        fill_d      = fill_q;
        vld_d       = vld_q;
        wr_ptr_d    = wr_ptr_q;
        sto_valid_d = sto_valid_q;
        sto_data_d  = sto_data_q;

        if (cfg_load) begin
            cur_dly_d   = dly_clamp;
            fill_base   = dly_clamp;
            vld_d       = '0;
            sto_valid_d = 1'b0;
        end
        fill_d = fill_base;

        if (sti_en) begin
            if (fill_base != '0) begin
                fill_d = fill_base - AW'(1);
            end
            vld_d[wr_ptr_q] = sti_valid;
            wr_ptr_d        = (wr_ptr_q == PW'(MAX_DLY - 1)) ? '0 : wr_ptr_q + 1'b1;
            // Output stays invalid until the line has refilled, whatever the flags say.
            sto_valid_d     = rd_valid && (fill_d == '0);
            sto_data_d      = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_dly_q   <= AW'(DEF_DLY);
            fill_q      <= AW'(DEF_DLY);
            vld_q       <= '0;
            wr_ptr_q    <= '0;
            sto_valid_q <= 1'b0;
            sto_data_q  <= '0;
        end else begin
            cur_dly_q   <= cur_dly_d;
            fill_q      <= fill_d;
            vld_q       <= vld_d;
            wr_ptr_q    <= wr_ptr_d;
            sto_valid_q <= sto_valid_d;
            sto_data_q  <= sto_data_d;
        end
    end

    // Data RAM carries no reset; validity is tracked entirely by vld_q.
    always_ff @(posedge clk) begin
        if (sti_en) begin
            mem_q[wr_ptr_q] <= sti_data;
        end
    end

    assign sto_valid = sto_valid_q;
    assign sto_data  = sto_data_q;
    assign cur_dly   = cur_dly_q;
    assign busy      = (fill_q != '0);

endmodule
